// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with request-to-send.
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_TICKS = 1200,
    parameter int TIMEOUT_TICKS = 24000
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       CLK_OE,
    output logic       DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    localparam int CMAX = (INHIBIT_TICKS > TIMEOUT_TICKS) ?
                          INHIBIT_TICKS : TIMEOUT_TICKS;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAITIDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic [3:0]    bitn_q, bitn_d;
    logic          doe_q, doe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic ck_s1_q, ck_s2_q, ck_s3_q;
    logic dt_s1_q, dt_s2_q;
    logic fall_q;
    logic wd_hit;

    // Two-flop sync per line, plus a delayed copy for the registered edge.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            ck_s1_q <= 1'b1;
            ck_s2_q <= 1'b1;
            ck_s3_q <= 1'b1;
            dt_s1_q <= 1'b1;
            dt_s2_q <= 1'b1;
            fall_q  <= 1'b0;
        end else if (clk_en) begin
            ck_s1_q <= PS2_CLK;
            ck_s2_q <= ck_s1_q;
            ck_s3_q <= ck_s2_q;
            dt_s1_q <= PS2_DATA;
            dt_s2_q <= dt_s1_q;
            fall_q  <= ck_s3_q & ~ck_s2_q;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    assign wd_hit = (cnt_q == CW'(TIMEOUT_TICKS - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            bitn_q  <= '0;
            doe_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            par_q   <= par_d;
            bitn_q  <= bitn_d;
            doe_q   <= doe_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        par_d   = par_q;
        bitn_d  = bitn_q;
        doe_d   = doe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                doe_d = 1'b0;
                if (clk_en && TX_START && !done_q && !err_q) begin
                    data_d  = TX_DATA;
                    par_d   = ~^TX_DATA;
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (clk_en) begin
                    if (cnt_q == CW'(INHIBIT_TICKS - 1)) begin
                        doe_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (clk_en) begin
                    cnt_d   = '0;
                    bitn_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (clk_en) begin
                    if (fall_q) begin
                        cnt_d  = '0;
                        bitn_d = bitn_q + 1'b1;
                        if (bitn_q < 4'd8) begin
                            doe_d = ~data_q[bitn_q[2:0]];
                        end else if (bitn_q == 4'd8) begin
                            doe_d = ~par_q;
                        end else begin
                            doe_d   = 1'b0;
                            state_d = S_ACK;
                        end
                    end else if (wd_hit) begin
                        doe_d   = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (clk_en) begin
                    if (fall_q) begin
                        cnt_d = '0;
                        if (!dt_s2_q) begin
                            state_d = S_WAITIDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (wd_hit) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAITIDLE: begin
                if (clk_en) begin
                    if (ck_s2_q && dt_s2_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (fall_q) begin
                        cnt_d = '0;
                    end else if (wd_hit) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                doe_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign CLK_OE  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign DATA_OE = doe_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = done_q;
    assign ERROR   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized-tick bench with a behavioural PS/2 device.
// Covers frames, parity, NACK, ignored requests, reset and watchdog.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TO   = 150;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       clk_en = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_START = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       CLK_OE, DATA_OE, BUSY, DONE, ERROR;
    logic       ps2_clk, ps2_data;

    int tests = 0, fails = 0;
    int done_cnt = 0, err_cnt = 0, overlap = 0;

    assign ps2_clk  = dev_clk & ~CLK_OE;
    assign ps2_data = dev_data & ~DATA_OE;

    ps2_host_tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .nRESET(nRESET), .clk_en(clk_en),
        .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .TX_DATA(TX_DATA), .TX_START(TX_START),
        .CLK_OE(CLK_OE), .DATA_OE(DATA_OE), .BUSY(BUSY),
        .DONE(DONE), .ERROR(ERROR)
    );

    always #5 clk = ~clk;
    always @(posedge clk) clk_en <= ($urandom_range(0, 3) != 0);

    always @(negedge clk) begin
        if (DONE === 1'b1) done_cnt++;
        if (ERROR === 1'b1) err_cnt++;
        if ((DONE === 1'b1 || ERROR === 1'b1) && BUSY === 1'b1) overlap++;
    end

    // Expected wire frame: start, LSB-first data, odd parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, ((ones % 2) == 0), b, 1'b0};
    endfunction

    task automatic request(input logic [7:0] b, output int inh, output int both);
        int g;
        inh = 0;
        both = 0;
        @(negedge clk);
        TX_DATA = b;
        TX_START = 1'b1;
        g = 0;
        while (BUSY !== 1'b1 && g < 200) begin
            @(negedge clk);
            g++;
        end
        TX_START = 1'b0;
        g = 0;
        while (CLK_OE === 1'b1 && g < 2000) begin
            if (clk_en) begin
                inh++;
                if (DATA_OE) both++;
            end
            @(negedge clk);
            g++;
        end
    endtask

    task automatic dev_frame(input logic ack, input int abort_edge,
                             output logic [10:0] smp, output logic oe9);
        smp = '0;
        oe9 = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            repeat (HALF) @(posedge clk);
            #1 smp[n-1] = ps2_data;
            if (n == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            if (n == abort_edge) return;
            repeat (HALF) @(posedge clk);
            #1;
            if (n == 9) oe9 = DATA_OE;
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_idle;
        int g;
        g = 0;
        while (BUSY !== 1'b0 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] b, input logic ack, input string nm);
        int inh, both, d0, e0;
        logic [10:0] smp, exp;
        logic oe9;
        d0 = done_cnt;
        e0 = err_cnt;
        exp = frame_of(b);
        request(b, inh, both);
        tests++;
        if (inh !== INH + 1) begin
            fails++;
            $display("FAIL %s inhibit_ticks got %0d want %0d", nm, inh, INH + 1);
        end
        tests++;
        if (both !== 1) begin
            fails++;
            $display("FAIL %s start_overlap got %0d want 1", nm, both);
        end
        dev_frame(ack, 0, smp, oe9);
        wait_idle();
        tests++;
        if (smp !== exp) begin
            fails++;
            $display("FAIL %s frame got %b want %b", nm, smp, exp);
        end
        tests++;
        if (oe9 !== ~exp[9]) begin
            fails++;
            $display("FAIL %s parity_oe got %b want %b", nm, oe9, ~exp[9]);
        end
        tests++;
        if (done_cnt - d0 !== (ack ? 1 : 0)) begin
            fails++;
            $display("FAIL %s done_pulses got %0d want %0d", nm, done_cnt - d0, ack ? 1 : 0);
        end
        tests++;
        if (err_cnt - e0 !== (ack ? 0 : 1)) begin
            fails++;
            $display("FAIL %s error_pulses got %0d want %0d", nm, err_cnt - e0, ack ? 0 : 1);
        end
        tests++;
        if ({BUSY, CLK_OE, DATA_OE} !== 3'b000) begin
            fails++;
            $display("FAIL %s idle_lines got %b want 000", nm, {BUSY, CLK_OE, DATA_OE});
        end
    endtask

    task automatic test_reset;
        nRESET = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if ({CLK_OE, DATA_OE, BUSY, DONE, ERROR} !== 5'b0) begin
            fails++;
            $display("FAIL reset outputs got %b want 00000",
                     {CLK_OE, DATA_OE, BUSY, DONE, ERROR});
        end
        nRESET = 1'b1;
        repeat (10) @(negedge clk);
        tests++;
        if ({CLK_OE, BUSY, done_cnt, err_cnt} !== {2'b00, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL post_reset idle got busy=%b done=%0d err=%0d want 0",
                     BUSY, done_cnt, err_cnt);
        end
    endtask

    task automatic test_ed;
        run_frame(8'hED, 1'b1, "send_ED");
    endtask

    task automatic test_parity;
        run_frame(8'h00, 1'b1, "send_00");
        run_frame(8'hFF, 1'b1, "send_FF");
    endtask

    task automatic test_nack;
        run_frame(8'hF3, 1'b0, "nack_F3");
    endtask

    task automatic test_ignore;
        int inh, both, d0;
        logic [10:0] smp, exp;
        logic oe9;
        d0 = done_cnt;
        exp = frame_of(8'hF4);
        request(8'hF4, inh, both);
        fork
            dev_frame(1'b1, 0, smp, oe9);
            begin
                repeat (3 * HALF) @(negedge clk);
                TX_DATA = 8'h55;
                TX_START = 1'b1;
                repeat (6) @(negedge clk);
                TX_START = 1'b0;
            end
        join
        wait_idle();
        tests++;
        if (smp !== exp) begin
            fails++;
            $display("FAIL ignore frame got %b want %b", smp, exp);
        end
        tests++;
        if (done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL ignore done_pulses got %0d want 1", done_cnt - d0);
        end
        repeat (50) @(negedge clk);
        tests++;
        if (BUSY !== 1'b0) begin
            fails++;
            $display("FAIL ignore requeued busy got %b want 0", BUSY);
        end
    endtask

    task automatic test_midreset;
        int inh, both, d0, e0;
        logic [10:0] smp;
        logic oe9;
        request(8'hF4, inh, both);
        dev_frame(1'b1, 5, smp, oe9);
        repeat (HALF) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        tests++;
        if (BUSY !== 1'b1) begin
            fails++;
            $display("FAIL midreset busy_before got %b want 1", BUSY);
        end
        nRESET = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if ({CLK_OE, DATA_OE, BUSY} !== 3'b000) begin
            fails++;
            $display("FAIL midreset released got %b want 000", {CLK_OE, DATA_OE, BUSY});
        end
        @(negedge clk);
        nRESET = 1'b1;
        dev_clk = 1'b1;
        repeat (30) @(negedge clk);
        tests++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            fails++;
            $display("FAIL midreset pulses got done=%0d err=%0d want 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        run_frame(8'hEE, 1'b1, "after_reset_EE");
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic ack;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            run_frame(b, ack, $sformatf("rand%0d_%02h", i, b));
        end
    endtask

    task automatic test_timeout;
        int inh, both, g, t, e0;
        e0 = err_cnt;
        request(8'h5A, inh, both);
        t = 0;
        g = 0;
`ifdef PS2_TX_TIMEOUT_EN
        while (ERROR !== 1'b1 && g < TO * 10) begin
            if (clk_en) t++;
            @(negedge clk);
            g++;
        end
        tests++;
        if (t !== TO) begin
            fails++;
            $display("FAIL timeout ticks got %0d want %0d", t, TO);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (err_cnt - e0 !== 1 || {BUSY, CLK_OE, DATA_OE} !== 3'b000) begin
            fails++;
            $display("FAIL timeout abort got err=%0d lines=%b want 1 000",
                     err_cnt - e0, {BUSY, CLK_OE, DATA_OE});
        end
`else
        while (t < 3 * TO && g < TO * 20) begin
            if (clk_en) t++;
            @(negedge clk);
            g++;
        end
        tests++;
        if (BUSY !== 1'b1 || err_cnt - e0 !== 0) begin
            fails++;
            $display("FAIL no_timeout got busy=%b err=%0d want 1 0", BUSY, err_cnt - e0);
        end
        nRESET = 1'b0;
        @(negedge clk);
        nRESET = 1'b1;
        repeat (5) @(negedge clk);
        tests++;
        if ({BUSY, CLK_OE, DATA_OE} !== 3'b000) begin
            fails++;
            $display("FAIL no_timeout reset got %b want 000", {BUSY, CLK_OE, DATA_OE});
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ed();
        test_parity();
        test_nack();
        test_ignore();
        test_midreset();
        test_random();
        test_timeout();
        tests++;
        if (overlap !== 0) begin
            fails++;
            $display("FAIL pulse_while_busy got %0d want 0", overlap);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
